// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter and fetch sequencer.
// Runs the fetch handshake with instruction memory, chooses the next PC from
// the evaluator's branch decision, and owns the carry flag the evaluator reads.
// Optional feature: define PC_SEQ_LINK_EN to add a link-address register
// (i_link / o_linkAddr) that captures pc+1 on taken linked jumps.
module pc_sequencer #(
  parameter int                PC_W     = 16,
  parameter int                INSTR_W  = 16,
  parameter logic [PC_W-1:0]   RESET_PC = 16'h0000
) (
  input  logic               i_clk,
  input  logic               i_rst,
  output logic               o_fetchReq,
  output logic [PC_W-1:0]    o_fetchAddr,
  input  logic               i_fetchAck,
  input  logic [INSTR_W-1:0] i_instr,
  output logic [INSTR_W-1:0] o_instr,
  output logic               o_instrValid,
  input  logic               i_execDone,
  input  logic               i_isJump,
  input  logic               i_cond,
  input  logic [PC_W-1:0]    i_target,
  input  logic               i_halt,
  input  logic               i_carryIn,
  input  logic               i_carryWe,
  output logic               o_carry,
`ifdef PC_SEQ_LINK_EN
  input  logic               i_link,
  output logic [PC_W-1:0]    o_linkAddr,
`endif
  output logic [PC_W-1:0]    o_pc,
  output logic               o_halted
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t             r_state;
  logic [PC_W-1:0]    r_pc;
  logic [INSTR_W-1:0] r_instr;
  logic               r_instrValid;
  logic               r_carry;
  logic               r_halted;
  logic [PC_W-1:0]    w_pcInc;
  logic               w_taken;
`ifdef PC_SEQ_LINK_EN
  logic [PC_W-1:0]    r_linkAddr;
`endif

  // Sequential PC increment; the adder simply drops the carry so FFFF wraps to 0000.
  assign w_pcInc = r_pc + {{(PC_W-1){1'b0}}, 1'b1};
  assign w_taken = i_isJump & i_cond;

  assign o_fetchReq   = (r_state == S_FETCH);
  assign o_fetchAddr  = r_pc;
  assign o_pc         = r_pc;
  assign o_instr      = r_instr;
  assign o_instrValid = r_instrValid;
  assign o_carry      = r_carry;
  assign o_halted     = r_halted;
`ifdef PC_SEQ_LINK_EN
  assign o_linkAddr   = r_linkAddr;
`endif

  // Fetch/exec/halt state machine with PC update and registered decoder outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_FETCH;
      r_pc         <= RESET_PC;
      r_instr      <= '0;
      r_instrValid <= 1'b0;
      r_halted     <= 1'b0;
`ifdef PC_SEQ_LINK_EN
      r_linkAddr   <= '0;
`endif
    end else begin
      r_instrValid <= 1'b0;
      case (r_state)
        S_FETCH: begin
          if (i_fetchAck) begin
            r_instr      <= i_instr;
            r_instrValid <= 1'b1;
            r_state      <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (i_execDone) begin
            if (i_halt) begin
              r_state  <= S_HALT;
              r_halted <= 1'b1;
            end else if (w_taken) begin
              r_pc    <= i_target;
              r_state <= S_FETCH;
`ifdef PC_SEQ_LINK_EN
              if (i_link) begin
                r_linkAddr <= w_pcInc;
              end
`endif
            end else begin
              r_pc    <= w_pcInc;
              r_state <= S_FETCH;
            end
          end
        end
        S_HALT: begin
          r_state  <= S_HALT;
          r_halted <= 1'b1;
        end
        default: begin
          r_state <= S_FETCH;
        end
      endcase
    end
  end

  // Carry flag: written in any state; the evaluator only ever sees the registered value.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_carry <= 1'b0;
    end else if (i_carryWe) begin
      r_carry <= i_carryIn;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed self-checking bench for pc_sequencer.
// Inputs change and outputs are sampled on the falling clock edge.
`timescale 1ns/1ps
module tb_pc_sequencer;

  localparam int PC_W    = 16;
  localparam int INSTR_W = 16;

  logic               i_clk = 1'b0;
  logic               i_rst;
  logic               o_fetchReq;
  logic [PC_W-1:0]    o_fetchAddr;
  logic               i_fetchAck;
  logic [INSTR_W-1:0] i_instr;
  logic [INSTR_W-1:0] o_instr;
  logic               o_instrValid;
  logic               i_execDone;
  logic               i_isJump;
  logic               i_cond;
  logic [PC_W-1:0]    i_target;
  logic               i_halt;
  logic               i_carryIn;
  logic               i_carryWe;
  logic               o_carry;
  logic [PC_W-1:0]    o_pc;
  logic               o_halted;
`ifdef PC_SEQ_LINK_EN
  logic               i_link;
  logic [PC_W-1:0]    o_linkAddr;
`endif

  int testsRun = 0;
  int testsFailed = 0;

  pc_sequencer #(.PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC(16'h0000)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .o_fetchReq   (o_fetchReq),
    .o_fetchAddr  (o_fetchAddr),
    .i_fetchAck   (i_fetchAck),
    .i_instr      (i_instr),
    .o_instr      (o_instr),
    .o_instrValid (o_instrValid),
    .i_execDone   (i_execDone),
    .i_isJump     (i_isJump),
    .i_cond       (i_cond),
    .i_target     (i_target),
    .i_halt       (i_halt),
    .i_carryIn    (i_carryIn),
    .i_carryWe    (i_carryWe),
    .o_carry      (o_carry),
`ifdef PC_SEQ_LINK_EN
    .i_link       (i_link),
    .o_linkAddr   (o_linkAddr),
`endif
    .o_pc         (o_pc),
    .o_halted     (o_halted)
  );

  // 100 MHz clock.
  always #5 i_clk = ~i_clk;

  // Hard stop in case something stalls the sequence.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic idleInputs();
    i_fetchAck = 1'b0;
    i_instr    = '0;
    i_execDone = 1'b0;
    i_isJump   = 1'b0;
    i_cond     = 1'b0;
    i_target   = '0;
    i_halt     = 1'b0;
    i_carryIn  = 1'b0;
    i_carryWe  = 1'b0;
`ifdef PC_SEQ_LINK_EN
    i_link     = 1'b0;
`endif
  endtask

  // Acknowledge the pending fetch; returns one falling edge later in EXEC.
  task automatic doFetch(input logic [INSTR_W-1:0] instr);
    i_fetchAck = 1'b1;
    i_instr    = instr;
    @(negedge i_clk);
    i_fetchAck = 1'b0;
    i_instr    = '0;
  endtask

  // Finish the current instruction; returns one falling edge later.
  task automatic doExec(input logic isJump, input logic cond,
                        input logic [PC_W-1:0] target, input logic halt);
    i_execDone = 1'b1;
    i_isJump   = isJump;
    i_cond     = cond;
    i_target   = target;
    i_halt     = halt;
    @(negedge i_clk);
    idleInputs();
  endtask

  // Taken jump to a chosen address, used to position the PC.
  task automatic gotoPc(input logic [PC_W-1:0] addr);
    doFetch(16'h0000);
    doExec(1'b1, 1'b1, addr, 1'b0);
  endtask

  task automatic test_reset();
    idleInputs();
    i_rst = 1'b1;
    @(negedge i_clk);
    @(negedge i_clk);
    testsRun++;
    if (o_fetchReq !== 1'b1) begin
      testsFailed++; $display("[TB] FAIL reset_fetchReq got %b want 1", o_fetchReq);
    end
    testsRun++;
    if (o_pc !== 16'h0000 || o_fetchAddr !== 16'h0000) begin
      testsFailed++; $display("[TB] FAIL reset_pc got %h/%h want 0000", o_pc, o_fetchAddr);
    end
    testsRun++;
    if (o_instr !== 16'h0000 || o_instrValid !== 1'b0 || o_carry !== 1'b0 || o_halted !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_outputs got instr=%h valid=%b carry=%b halted=%b want 0000/0/0/0",
               o_instr, o_instrValid, o_carry, o_halted);
    end
`ifdef PC_SEQ_LINK_EN
    testsRun++;
    if (o_linkAddr !== 16'h0000) begin
      testsFailed++; $display("[TB] FAIL reset_link got %h want 0000", o_linkAddr);
    end
`endif
    i_rst = 1'b0;
  endtask

  task automatic test_fetch();
    // Hold off the ack for cycles 0..2, acknowledge in cycle 3.
    for (int c = 0; c < 4; c++) begin
      @(negedge i_clk);
      testsRun++;
      if (o_fetchReq !== 1'b1 || o_fetchAddr !== 16'h0000) begin
        testsFailed++;
        $display("[TB] FAIL fetch_wait c%0d got req=%b addr=%h want 1/0000", c, o_fetchReq, o_fetchAddr);
      end
      if (c == 3) begin
        i_fetchAck = 1'b1;
        i_instr    = 16'h1234;
      end
    end
    @(negedge i_clk);
    i_fetchAck = 1'b0;
    i_instr    = '0;
    testsRun++;
    if (o_instr !== 16'h1234 || o_instrValid !== 1'b1 || o_fetchReq !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL fetch_latch got instr=%h valid=%b req=%b want 1234/1/0",
               o_instr, o_instrValid, o_fetchReq);
    end
    // A stray ack while executing must be ignored.
    i_fetchAck = 1'b1;
    i_instr    = 16'h5555;
    @(negedge i_clk);
    i_fetchAck = 1'b0;
    i_instr    = '0;
    testsRun++;
    if (o_instrValid !== 1'b0 || o_instr !== 16'h1234 || o_fetchReq !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL fetch_pulse got valid=%b instr=%h req=%b want 0/1234/0",
               o_instrValid, o_instr, o_fetchReq);
    end
    doExec(1'b1, 1'b1, 16'h0005, 1'b0);
  endtask

  task automatic test_increment();
    testsRun++;
    if (o_fetchAddr !== 16'h0005 || o_fetchReq !== 1'b1) begin
      testsFailed++; $display("[TB] FAIL inc_setup got %h req=%b want 0005/1", o_fetchAddr, o_fetchReq);
    end
    // A done pulse while fetching must not move the PC.
    i_execDone = 1'b1; i_isJump = 1'b1; i_cond = 1'b1; i_target = 16'hBEEF;
    @(negedge i_clk);
    idleInputs();
    testsRun++;
    if (o_pc !== 16'h0005 || o_fetchReq !== 1'b1) begin
      testsFailed++; $display("[TB] FAIL inc_ignore_done got %h req=%b want 0005/1", o_pc, o_fetchReq);
    end
    doFetch(16'h0001);
    doExec(1'b0, 1'b0, 16'h0000, 1'b0);
    testsRun++;
    if (o_fetchAddr !== 16'h0006 || o_fetchReq !== 1'b1) begin
      testsFailed++; $display("[TB] FAIL inc_seq got %h want 0006", o_fetchAddr);
    end
    gotoPc(16'hFFFF);
    doFetch(16'h0002);
    doExec(1'b0, 1'b1, 16'h1111, 1'b0);
    testsRun++;
    if (o_fetchAddr !== 16'h0000) begin
      testsFailed++; $display("[TB] FAIL inc_wrap got %h want 0000", o_fetchAddr);
    end
  endtask

  task automatic test_jump();
    gotoPc(16'h0010);
    doFetch(16'h0003);
    doExec(1'b1, 1'b1, 16'h0100, 1'b0);
    testsRun++;
    if (o_fetchAddr !== 16'h0100) begin
      testsFailed++; $display("[TB] FAIL jump_taken got %h want 0100", o_fetchAddr);
    end
    gotoPc(16'h0010);
    doFetch(16'h0004);
    doExec(1'b1, 1'b0, 16'h0100, 1'b0);
    testsRun++;
    if (o_fetchAddr !== 16'h0011) begin
      testsFailed++; $display("[TB] FAIL jump_untaken got %h want 0011", o_fetchAddr);
    end
  endtask

  task automatic test_carry();
    doFetch(16'h0005);
    testsRun++;
    if (o_carry !== 1'b0) begin
      testsFailed++; $display("[TB] FAIL carry_pre got %b want 0", o_carry);
    end
    // Jump-if-carry: evaluator sees the registered carry (0), so the jump is not taken.
    i_execDone = 1'b1; i_isJump = 1'b1; i_cond = 1'b0; i_target = 16'h0200;
    i_carryWe  = 1'b1; i_carryIn = 1'b1;
    @(negedge i_clk);
    idleInputs();
    testsRun++;
    if (o_fetchAddr !== 16'h0012 || o_carry !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL carry_same_cycle got addr=%h carry=%b want 0012/1", o_fetchAddr, o_carry);
    end
    @(negedge i_clk);
    testsRun++;
    if (o_carry !== 1'b1) begin
      testsFailed++; $display("[TB] FAIL carry_hold got %b want 1", o_carry);
    end
    // Now the evaluator sees carry=1 and takes the jump.
    doFetch(16'h0006);
    doExec(1'b1, 1'b1, 16'h0200, 1'b0);
    testsRun++;
    if (o_fetchAddr !== 16'h0200) begin
      testsFailed++; $display("[TB] FAIL carry_taken got %h want 0200", o_fetchAddr);
    end
  endtask

  task automatic test_halt();
    gotoPc(16'h0020);
    doFetch(16'h0007);
    doExec(1'b1, 1'b1, 16'h0300, 1'b1);
    testsRun++;
    if (o_halted !== 1'b1 || o_pc !== 16'h0020 || o_fetchReq !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL halt_enter got halted=%b pc=%h req=%b want 1/0020/0", o_halted, o_pc, o_fetchReq);
    end
    for (int k = 0; k < 3; k++) begin
      i_fetchAck = 1'b1; i_instr = 16'hAAAA;
      i_execDone = 1'b1; i_isJump = 1'b1; i_cond = 1'b1; i_target = 16'h0400;
      @(negedge i_clk);
      idleInputs();
      testsRun++;
      if (o_halted !== 1'b1 || o_pc !== 16'h0020 || o_fetchReq !== 1'b0 || o_instrValid !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL halt_stay k%0d got halted=%b pc=%h req=%b valid=%b want 1/0020/0/0",
                 k, o_halted, o_pc, o_fetchReq, o_instrValid);
      end
    end
    // Carry stays writable while halted.
    i_carryWe = 1'b1; i_carryIn = 1'b0;
    @(negedge i_clk);
    idleInputs();
    testsRun++;
    if (o_carry !== 1'b0) begin
      testsFailed++; $display("[TB] FAIL halt_carry got %b want 0", o_carry);
    end
    i_rst = 1'b1;
    #1;
    testsRun++;
    if (o_halted !== 1'b0 || o_pc !== 16'h0000 || o_fetchReq !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL halt_reset got halted=%b pc=%h req=%b want 0/0000/1", o_halted, o_pc, o_fetchReq);
    end
    @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  task automatic test_reset_mid_exec();
    gotoPc(16'h0042);
    doFetch(16'h0008);
    testsRun++;
    if (o_pc !== 16'h0042 || o_instrValid !== 1'b1) begin
      testsFailed++; $display("[TB] FAIL rst_exec_setup got pc=%h valid=%b want 0042/1", o_pc, o_instrValid);
    end
    i_rst = 1'b1;
    #1;
    testsRun++;
    if (o_pc !== 16'h0000 || o_instrValid !== 1'b0 || o_fetchReq !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL rst_exec_abort got pc=%h valid=%b req=%b want 0000/0/1", o_pc, o_instrValid, o_fetchReq);
    end
    @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    testsRun++;
    if (o_fetchAddr !== 16'h0000 || o_fetchReq !== 1'b1) begin
      testsFailed++; $display("[TB] FAIL rst_exec_refetch got %h req=%b want 0000/1", o_fetchAddr, o_fetchReq);
    end
  endtask

`ifdef PC_SEQ_LINK_EN
  task automatic test_link();
    gotoPc(16'h0007);
    doFetch(16'h0009);
    i_link = 1'b1;
    doExec(1'b1, 1'b1, 16'h0050, 1'b0);
    testsRun++;
    if (o_linkAddr !== 16'h0008 || o_fetchAddr !== 16'h0050) begin
      testsFailed++; $display("[TB] FAIL link_taken got link=%h addr=%h want 0008/0050", o_linkAddr, o_fetchAddr);
    end
    doFetch(16'h000A);
    i_link = 1'b1;
    doExec(1'b1, 1'b0, 16'h0090, 1'b0);
    testsRun++;
    if (o_linkAddr !== 16'h0008 || o_fetchAddr !== 16'h0051) begin
      testsFailed++; $display("[TB] FAIL link_untaken got link=%h addr=%h want 0008/0051", o_linkAddr, o_fetchAddr);
    end
  endtask
`endif

  initial begin
    idleInputs();
    i_rst = 1'b1;
    test_reset();
    test_fetch();
    test_increment();
    test_jump();
    test_carry();
    test_halt();
    test_reset_mid_exec();
`ifdef PC_SEQ_LINK_EN
    test_link();
`endif
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
